// File: rtl/wb_trace_if.sv
// Writeback trace and golden-stream bundle between the core side and the checker.
// master drives the retire trace and golden entries; slave accepts them.
interface wb_trace_if;
  logic [31:0] wb_pc;
  logic [3:0]  wb_rf_we;
  logic [4:0]  wb_rf_wnum;
  logic [31:0] wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;

  modport master (
    output wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
    output gold_valid, gold_pc, gold_wnum, gold_wdata,
    input  gold_ready
  );

  modport slave (
    input  wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata,
    input  gold_valid, gold_pc, gold_wnum, gold_wdata,
    output gold_ready
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Compares retired register writes against a buffered golden trace,
// latching the first divergence and flagging completion at END_PC.
module wb_trace_checker #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'h1c000100
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_trace_if.slave                tr,
  output logic [1:0]               state,
  output logic [1:0]               err_code,
  output logic [31:0]              err_got_pc,
  output logic [31:0]              err_exp_pc,
  output logic [4:0]               err_got_wnum,
  output logic [4:0]               err_exp_wnum,
  output logic [31:0]              err_got_wdata,
  output logic [31:0]              err_exp_wdata,
  output logic [31:0]              cmp_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  state_t          st_q;
  state_t          st_d;
  gold_t           mem [DEPTH];
  gold_t           head;
  gold_t           got;
  gold_t           exp_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            commit;
  logic            set_err;
  logic [1:0]      code_d;
  logic            cnt_inc;

  assign full   = level == LW'(DEPTH);
  assign empty  = level == '0;
  assign push   = tr.gold_valid && !full;
  assign head   = mem[rd_ptr];
  assign got    = '{pc: tr.wb_pc, wnum: tr.wb_rf_wnum,
                    wdata: tr.wb_rf_wdata};
  assign commit = (st_q == S_RUN) && (tr.wb_rf_we != '0)
                  && (tr.wb_rf_wnum != '0);

  always_comb begin
    st_d    = st_q;
    set_err = 1'b0;
    code_d  = 2'd0;
    exp_d   = '0;
    cnt_inc = 1'b0;
    pop     = 1'b0;
    unique case (st_q)
      S_IDLE: st_d = S_RUN;
      S_RUN: begin
        if (commit) begin
          if (empty) begin
            set_err = 1'b1;
            code_d  = 2'd2;
          end else begin
            pop = 1'b1;
            if (head != got) begin
              set_err = 1'b1;
              code_d  = 2'd1;
              exp_d   = head;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        // A divergence on the END_PC cycle wins over completion
        if (set_err)
          st_d = S_ERROR;
        else if (tr.wb_pc == END_PC)
          st_d = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= got_push();
  end

  function automatic gold_t got_push();
    return '{pc: tr.gold_pc, wnum: tr.gold_wnum,
             wdata: tr.gold_wdata};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      cmp_cnt       <= '0;
      err_code      <= 2'd0;
      err_got_pc    <= '0;
      err_exp_pc    <= '0;
      err_got_wnum  <= '0;
      err_exp_wnum  <= '0;
      err_got_wdata <= '0;
      err_exp_wdata <= '0;
    end else begin
      st_q  <= st_d;
      level <= level + LW'(push) - LW'(pop);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (cnt_inc && cmp_cnt != 32'hFFFF_FFFF)
        cmp_cnt <= cmp_cnt + 32'd1;
      if (set_err) begin
        err_code      <= code_d;
        err_got_pc    <= got.pc;
        err_got_wnum  <= got.wnum;
        err_got_wdata <= got.wdata;
        err_exp_pc    <= exp_d.pc;
        err_exp_wnum  <= exp_d.wnum;
        err_exp_wdata <= exp_d.wdata;
      end
    end
  end

  assign tr.gold_ready = !full;
  assign state         = st_q;
  assign fifo_level    = level;

endmodule
